// File: rtl/mem_access_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_bridge_pkg
// Description : Shared definitions for the memory access bridge: FSM state
//               encoding, default timeout and the MemRead/MemWrite opcodes
//               also used by the control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_bridge_pkg;

  // Bridge FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  // Default number of cycles mem_req may stay up without an ack
  localparam int unsigned C_TIMEOUT_DEFAULT = 15;

  // Request opcodes, encoded as {MemWrite, MemRead}
  localparam logic [1:0] C_OP_NONE    = 2'b00;
  localparam logic [1:0] C_OP_READ    = 2'b01;
  localparam logic [1:0] C_OP_WRITE   = 2'b10;
  localparam logic [1:0] C_OP_ILLEGAL = 2'b11;

  function automatic logic [1:0] op_of(input logic i_read, input logic i_write);
    return {i_write, i_read};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_bridge_if
// Description : CPU-side and memory-side signals of the bridge.
//               slave  : the bridge's view
//               master : the environment's view (datapath + memory)
//   cpu_addr/cpu_wdata/cpu_read/cpu_write : request from datapath
//   cpu_rdata/cpu_busy/cpu_done/cpu_fault : response to datapath
//   mem_req/mem_we/mem_addr/mem_wdata     : bus request
//   mem_rdata/mem_ack                     : bus response
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_read;
  logic              cpu_write;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_busy;
  logic              cpu_done;
  logic              cpu_fault;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_read, cpu_write, mem_rdata, mem_ack,
    output cpu_rdata, cpu_busy, cpu_done, cpu_fault,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_read, cpu_write, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_busy, cpu_done, cpu_fault,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_bridge_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module      : mem_timeout_counter
// Description : Counts REQ cycles without an acknowledge.
//   clk, rst : clock, synchronous active-high reset
//   i_clr    : force count to zero
//   i_en     : increment count
//   o_tc     : count has reached TIMEOUT-1 (last allowed wait cycle)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_timeout_counter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_clr,
  input  wire logic i_en,
  output logic      o_tc
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == CNT_W'(TIMEOUT - 1));
endmodule
`default_nettype wire

// File: rtl/mem_access_bridge.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_bridge
// Description : Registers one datapath memory access at a time and drives it
//               onto a req/ack word bus, stalling the control unit until the
//               access completes (cpu_done) or is aborted (cpu_fault).
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_access_bridge_if.slave (CPU and memory sides)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_bridge
  import mem_access_bridge_pkg::*;
#(
  parameter int          ADDR_W  = 32,
  parameter int          DATA_W  = 32,
  parameter int unsigned TIMEOUT = C_TIMEOUT_DEFAULT
) (
  input wire logic              clk,
  input wire logic              rst,
  mem_access_bridge_if.slave    bus
);
  state_t            r_state;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_done;
  logic              r_fault;
  logic              w_tc;
  logic [1:0]        w_op;

  assign w_op = op_of(bus.cpu_read, bus.cpu_write);

  mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk  (clk),
    .rst  (rst),
    .i_clr(r_state == ST_IDLE),
    .i_en ((r_state == ST_REQ) && !bus.mem_ack),
    .o_tc (w_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_done  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_fault <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          case (w_op)
            C_OP_READ, C_OP_WRITE: begin
              r_addr  <= bus.cpu_addr;
              r_wdata <= bus.cpu_wdata;
              r_we    <= bus.cpu_write;
              r_req   <= 1'b1;
              r_state <= ST_REQ;
            end
            C_OP_ILLEGAL: begin
              r_fault <= 1'b1;
              r_state <= ST_FAULT;
            end
            default: ;
          endcase
        end
        ST_REQ: begin
          // An ack on the last allowed cycle still wins over the timeout
          if (bus.mem_ack) begin
            if (!r_we) begin
              r_rdata <= bus.mem_rdata;
            end
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else if (w_tc) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_fault <= 1'b1;
            r_state <= ST_FAULT;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Busy goes up in the same cycle the request is seen so the control unit
  // cannot step past an access that has not started yet.
  assign bus.cpu_busy  = !rst && ((r_state == ST_REQ) ||
                                  ((r_state == ST_IDLE) && (w_op != C_OP_NONE)));
  assign bus.cpu_rdata = r_rdata;
  assign bus.cpu_done  = r_done;
  assign bus.cpu_fault = r_fault;
  assign bus.mem_req   = r_req;
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
endmodule
`default_nettype wire

// File: tb/tb_mem_access_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_bridge
// Description : Self-checking bench for mem_access_bridge: table of single
//               accesses plus directed sequences for illegal request, late
//               ack, reset mid-access and back-to-back reads.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_bridge;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mem_access_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_access_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_at;     // REQ cycle (1-based) carrying the ack, 0 = never
    logic        late_ack;   // send a stray ack two cycles after the end
    logic        exp_done;
    logic        exp_fault;
    int          exp_req;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input int idx);
    vec_t v;
    int   req_cycles;
    v          = vecs[idx];
    req_cycles = 0;
    bus.cpu_read  = !v.wr;
    bus.cpu_write = v.wr;
    bus.cpu_addr  = v.addr;
    bus.cpu_wdata = v.wdata;
    #1;
    check($sformatf("v%0d busy_at_request", idx), bus.cpu_busy, 1);
    check($sformatf("v%0d no_req_yet", idx), bus.mem_req, 0);
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.mem_req !== 1'b1) break;
      req_cycles++;
      if (k == 1) begin
        check($sformatf("v%0d mem_addr", idx), bus.mem_addr, v.addr);
        check($sformatf("v%0d mem_we", idx), bus.mem_we, v.wr);
        if (v.wr) check($sformatf("v%0d mem_wdata", idx), bus.mem_wdata, v.wdata);
      end else if (bus.mem_addr !== v.addr || bus.mem_we !== v.wr) begin
        check($sformatf("v%0d bus_hold", idx), {bus.mem_we, bus.mem_addr}, {v.wr, v.addr});
      end
      // Disturb the CPU side; the bus must not follow
      bus.cpu_addr  = ~v.addr;
      bus.cpu_wdata = ~v.wdata;
      bus.mem_ack   = (k == v.ack_at);
      bus.mem_rdata = v.rdata;
      #1;
      if (bus.cpu_busy !== 1'b1) check($sformatf("v%0d busy_in_req", idx), bus.cpu_busy, 1);
    end
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    bus.cpu_read  = 1'b0;
    bus.cpu_write = 1'b0;
    #1;
    check($sformatf("v%0d req_cycles", idx), req_cycles, v.exp_req);
    check($sformatf("v%0d done", idx), bus.cpu_done, v.exp_done);
    check($sformatf("v%0d fault", idx), bus.cpu_fault, v.exp_fault);
    check($sformatf("v%0d busy_end", idx), bus.cpu_busy, 0);
    check($sformatf("v%0d rdata", idx), bus.cpu_rdata, v.exp_rdata);
    tick();
    check($sformatf("v%0d pulse_end", idx), {bus.cpu_done, bus.cpu_fault}, 2'b00);
    if (v.late_ack) begin
      tick();
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hBAD0BAD0;
      tick();
      bus.mem_ack = 1'b0;
      check($sformatf("v%0d late_ack_ignored", idx),
            {bus.cpu_done, bus.cpu_fault, bus.mem_req}, 3'b000);
      check($sformatf("v%0d late_ack_rdata", idx), bus.cpu_rdata, v.exp_rdata);
      tick();
      check($sformatf("v%0d late_ack_no_done", idx), bus.cpu_done, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    //            wr    addr          wdata         rdata         ack late done flt req exp_rdata
    vecs[0] = '{1'b0, 32'h00000004, 32'h0,        32'hCAFEF00D, 3,  1'b0, 1'b1, 1'b0, 3,  32'hCAFEF00D};
    vecs[1] = '{1'b1, 32'h00000010, 32'h12345678, 32'hFFFF0000, 1,  1'b0, 1'b1, 1'b0, 1,  32'hCAFEF00D};
    vecs[2] = '{1'b0, 32'h00000020, 32'h0,        32'hDEADBEEF, 0,  1'b1, 1'b0, 1'b1, 15, 32'hCAFEF00D};
    vecs[3] = '{1'b0, 32'h000003FF, 32'h0,        32'hA5A55A5A, 1,  1'b0, 1'b1, 1'b0, 1,  32'hA5A55A5A};
    vecs[4] = '{1'b1, 32'h00000007, 32'hFFFFFFFF, 32'h13572468, 15, 1'b0, 1'b1, 1'b0, 15, 32'hA5A55A5A};
    vecs[5] = '{1'b0, 32'h00000100, 32'h0,        32'h00000001, 14, 1'b0, 1'b1, 1'b0, 14, 32'h00000001};
    vecs[6] = '{1'b0, 32'h00000008, 32'h0,        32'h0BADC0DE, 2,  1'b0, 1'b1, 1'b0, 2,  32'h0BADC0DE};

    rst           = 1'b1;
    bus.cpu_addr  = 32'h0;
    bus.cpu_wdata = 32'h0;
    bus.cpu_read  = 1'b0;
    bus.cpu_write = 1'b0;
    bus.mem_rdata = 32'h0;
    bus.mem_ack   = 1'b0;
    tick();
    tick();
    check("reset_outputs",
          {bus.mem_req, bus.mem_we, bus.cpu_busy, bus.cpu_done, bus.cpu_fault}, 5'b0);
    check("reset_rdata", bus.cpu_rdata, 0);
    check("reset_addr_wdata", {bus.mem_addr, bus.mem_wdata}, 64'h0);
    rst = 1'b0;
    tick();
    // Stray ack in IDLE
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    check("idle_stray_ack", {bus.cpu_done, bus.cpu_fault, bus.mem_req}, 3'b000);

    for (int i = 0; i < 6; i++) begin
      run_txn(i);
    end

    // Illegal request: both strobes
    bus.cpu_read  = 1'b1;
    bus.cpu_write = 1'b1;
    #1;
    check("illegal_busy", bus.cpu_busy, 1);
    check("illegal_no_req", bus.mem_req, 0);
    tick();
    bus.cpu_read  = 1'b0;
    bus.cpu_write = 1'b0;
    #1;
    check("illegal_fault", {bus.cpu_fault, bus.cpu_done, bus.mem_req, bus.cpu_busy}, 4'b1000);
    tick();
    check("illegal_after", {bus.cpu_fault, bus.mem_req}, 2'b00);

    // Reset in REQ cycle 2
    bus.cpu_read = 1'b1;
    bus.cpu_addr = 32'h00000040;
    tick();
    check("rst_mid_req1", bus.mem_req, 1);
    tick();
    check("rst_mid_req2", bus.mem_req, 1);
    rst          = 1'b1;
    bus.cpu_read = 1'b0;
    tick();
    check("rst_mid_strobes",
          {bus.mem_req, bus.mem_we, bus.cpu_busy, bus.cpu_done, bus.cpu_fault}, 5'b0);
    check("rst_mid_data", {bus.mem_addr, bus.cpu_rdata}, 64'h0);
    check("rst_mid_wdata", bus.mem_wdata, 0);
    rst = 1'b0;
    tick();
    run_txn(6);

    // Back-to-back reads with cpu_read held across cpu_done
    bus.cpu_read = 1'b1;
    bus.cpu_addr = 32'h00000000;
    tick();
    check("b2b_req1", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h0});
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h11111111;
    tick();
    bus.mem_ack  = 1'b0;
    bus.cpu_addr = 32'h00000001;
    check("b2b_done1", {bus.cpu_done, bus.mem_req}, 2'b10);
    check("b2b_rdata1", bus.cpu_rdata, 32'h11111111);
    tick();
    check("b2b_idle_gap", {bus.mem_req, bus.cpu_busy}, 2'b01);
    tick();
    check("b2b_req2", {bus.mem_req, bus.mem_we, bus.mem_addr}, {2'b10, 32'h1});
    bus.cpu_addr = 32'h00000055;
    tick();
    check("b2b_addr_hold", bus.mem_addr, 32'h1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h22222222;
    tick();
    bus.mem_ack  = 1'b0;
    bus.cpu_read = 1'b0;
    check("b2b_done2", {bus.cpu_done, bus.cpu_fault}, 2'b10);
    check("b2b_rdata2", bus.cpu_rdata, 32'h22222222);
    tick();
    check("b2b_idle_end", {bus.mem_req, bus.cpu_busy, bus.cpu_done}, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_bridge.md
Name: mem_access_bridge

Overview:
- Sits between the multicycle datapath's memory port (IorD-selected address, RegB write data, MemRead/MemWrite from the control unit) and a variable-latency external word memory using a req/ack handshake.
- Registers each access and drives the bus until the memory acknowledges.
- Returns latched read data to the instruction register and memory data register, and tells the control unit to hold its current state (stall) until the access completes or times out.

Parameters:
- ADDR_W, 32, address width; addresses are word addresses, and the PC increments by 1.
- DATA_W, 32, data width.
- TIMEOUT, 15, maximum cycles mem_req may stay high without mem_ack before the access is aborted (range 1..255).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_addr  in  ADDR_W  access address (output of IorD mux).
- cpu_wdata  in  DATA_W  store data (RegB).
- cpu_read  in  1  MemRead from control unit; level, held until cpu_done.
- cpu_write  in  1  MemWrite from control unit; level, held until cpu_done.
- cpu_rdata  out  DATA_W  last successfully read word; feeds IR/MDR.
- cpu_busy  out  1  stall request to control unit.
- cpu_done  out  1  one-cycle pulse: access completed.
- cpu_fault  out  1  one-cycle pulse: access aborted (timeout or illegal request).
- mem_req  out  1  bus request.
- mem_we  out  1  bus write enable, valid while mem_req=1.
- mem_addr  out  ADDR_W  bus address, stable while mem_req=1.
- mem_wdata  out  DATA_W  bus write data, stable while mem_req=1.
- mem_rdata  in  DATA_W  bus read data, sampled on the cycle mem_ack=1.
- mem_ack  in  1  bus acknowledge; single-cycle.

Behaviour:
- Reset: all outputs 0, including cpu_rdata=0, mem_addr=0 and mem_wdata=0. State is IDLE and the timeout counter is 0.
- Reset mid-access: mem_req drops at the reset edge and any pending ack is lost. Memory must tolerate an abandoned request.
- States: IDLE, REQ, DONE, FAULT.
- IDLE, with (cpu_read XOR cpu_write)=1:
  - Capture cpu_addr, cpu_wdata and cpu_write into mem_addr, mem_wdata and mem_we.
  - Set mem_req=1 and cpu_busy=1, clear the counter, go to REQ.
  - The capture happens at edge N, so the outputs are visible in cycle N+1.
- IDLE, with cpu_read=1 and cpu_write=1: illegal request. Go to FAULT, no bus request, cpu_busy=1 for that one cycle.
- IDLE, no request: all strobes 0. A stray mem_ack is ignored.
- REQ:
  - mem_req=1. Address, data and we are held constant. cpu_read/cpu_write changes are ignored.
  - On mem_ack=1: if it is a read, latch mem_rdata into cpu_rdata. Clear mem_req, go to DONE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without ack, clear mem_req and go to FAULT.
  - An ack in the first REQ cycle is legal. Minimum latency from request to cpu_done is 2 cycles.
- DONE:
  - cpu_done=1 and cpu_busy=0 for exactly one cycle; then go to IDLE.
  - A new request is accepted only from IDLE, so there is at most one access per 3 cycles. The control unit deasserts MemRead/MemWrite on seeing cpu_done.
- FAULT:
  - cpu_fault=1 and cpu_busy=0 for one cycle; then go to IDLE.
  - cpu_rdata is unchanged. A late mem_ack in FAULT or IDLE is ignored.
- cpu_busy is 1 in REQ, and in the IDLE->REQ/FAULT transition cycle combinationally: it is asserted the same cycle the request is seen, so the control unit never advances on an unstarted access.
- Write accesses never modify cpu_rdata.
- cpu_done and cpu_fault are never asserted together.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, REQ=2'd1, DONE=2'd2, FAULT=2'd3;
  - the default TIMEOUT constant;
  - the read/write opcode constants also used by the control unit.
- One sub-module, mem_timeout_counter: clear, enable, terminal-count output, width $clog2(TIMEOUT+1).
- FSM and datapath registers stay in the top.

Test Plan:
- Read, ack after 3 cycles:
  - Stimulus: cpu_read=1, cpu_addr=0x00000004, mem_rdata=0xCAFEF00D.
  - Required: mem_req high for 3 cycles with mem_addr=0x4 and mem_we=0; cpu_done pulse one cycle after ack; cpu_rdata=0xCAFEF00D; cpu_busy low during DONE.
- Write, ack in first REQ cycle:
  - Stimulus: cpu_write=1, addr=0x10, wdata=0x12345678.
  - Required: mem_we=1 and mem_wdata=0x12345678 for one cycle; cpu_done 2 cycles after request; cpu_rdata unchanged.
- Timeout (TIMEOUT=15):
  - Stimulus: read, no ack.
  - Required: mem_req high exactly 15 cycles; cpu_fault pulse; cpu_rdata unchanged; a late ack 2 cycles after the fault produces no cpu_done.
- Illegal request:
  - Stimulus: cpu_read=cpu_write=1.
  - Required: no mem_req ever; cpu_fault on the next cycle.
- Reset mid-access:
  - Stimulus: rst=1 at REQ cycle 2.
  - Required: mem_req=0 and cpu_busy=0 after the edge; all outputs 0; a subsequent read completes normally.
- Back-to-back reads:
  - Stimulus: cpu_read held across cpu_done, changing addr 0x0 -> 0x1.
  - Required: second mem_req starts 2 cycles after the first cpu_done with mem_addr=0x1; cpu_addr changes during REQ do not alter mem_addr.
